// File: rtl/rx_reset_sequencer_pkg.sv
// Shared definitions for the receiver reset sequencer and its register-file decoder.
package rx_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    RSQ_IDLE    = 2'd0,
    RSQ_ASSERT  = 2'd1,
    RSQ_HOLDOFF = 2'd2
  } rsq_state_e;

  localparam int unsigned RSQ_NUM_SRC       = 2;
  localparam int unsigned RSQ_RST_LEN_WIDTH = 8;
  localparam int unsigned RSQ_HOLDOFF_WIDTH = 16;
  localparam int unsigned RSQ_CNT_WIDTH     = 16;

endpackage

// File: rtl/rx_reset_sequencer_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/rx_reset_sequencer.sv
// Arbitrates receiver reset requests into a registered, stretched reset pulse
// followed by a holdoff window, and records cause and event/drop statistics.
module rx_reset_sequencer
  import rx_reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SRC       = RSQ_NUM_SRC,
  parameter int unsigned RST_LEN_WIDTH = RSQ_RST_LEN_WIDTH,
  parameter int unsigned HOLDOFF_WIDTH = RSQ_HOLDOFF_WIDTH,
  parameter int unsigned CNT_WIDTH     = RSQ_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic [NUM_SRC-1:0]       rst_req,
  input  logic                     sw_rst_req,
  input  logic [RST_LEN_WIDTH-1:0] rst_len,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_len,
  input  logic                     clr_cnt,
  output logic                     receiver_rst,
  output logic                     busy,
  output logic [NUM_SRC:0]         rst_cause,
  output logic [CNT_WIDTH-1:0]     event_cnt,
  output logic [CNT_WIDTH-1:0]     drop_cnt
);

  localparam logic [RST_LEN_WIDTH-1:0] LEN_ONE  = {{(RST_LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [HOLDOFF_WIDTH-1:0] HOLD_ONE = {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NUM_SRC:0]         SW_ONLY  = {1'b1, {NUM_SRC{1'b0}}};

  rsq_state_e               state_q, state_d;
  logic [RST_LEN_WIDTH-1:0] asrt_cnt_q, asrt_cnt_d;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic [NUM_SRC:0]         cause_q, cause_d;
  logic                     receiver_rst_q, receiver_rst_d;
  logic                     busy_q, busy_d;

  logic                     hw_req;
  logic                     trig;
  logic [RST_LEN_WIDTH-1:0] eff_len;
  logic [NUM_SRC:0]         req_cause;
  logic                     event_inc;
  logic                     drop_inc;

  assign hw_req    = |rst_req;
  assign trig      = (enable & hw_req) | sw_rst_req;
  assign eff_len   = (rst_len == '0) ? LEN_ONE : rst_len;
  assign req_cause = {sw_rst_req, rst_req & {NUM_SRC{enable}}};

  always_comb begin
    state_d    = state_q;
    asrt_cnt_d = asrt_cnt_q;
    hold_cnt_d = hold_cnt_q;
    cause_d    = cause_q;
    event_inc  = 1'b0;
    drop_inc   = 1'b0;

    case (state_q)
      RSQ_IDLE: begin
        if (trig) begin
          state_d    = RSQ_ASSERT;
          asrt_cnt_d = eff_len;
          cause_d    = req_cause;
          event_inc  = 1'b1;
        end
      end

      RSQ_ASSERT: begin
        cause_d = cause_q | req_cause;
        if (asrt_cnt_q <= LEN_ONE) begin
          asrt_cnt_d = '0;
          if (holdoff_len != '0) begin
            state_d    = RSQ_HOLDOFF;
            hold_cnt_d = holdoff_len;
          end else begin
            state_d = RSQ_IDLE;
          end
        end else begin
          asrt_cnt_d = asrt_cnt_q - LEN_ONE;
        end
      end

      RSQ_HOLDOFF: begin
        drop_inc = hw_req;
        // Software request cuts the blanking window short; hardware ones are only counted.
        if (sw_rst_req) begin
          state_d    = RSQ_ASSERT;
          asrt_cnt_d = eff_len;
          hold_cnt_d = '0;
          cause_d    = SW_ONLY;
          event_inc  = 1'b1;
        end else if (hold_cnt_q <= HOLD_ONE) begin
          state_d    = RSQ_IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
        end
      end

      default: begin
        state_d    = RSQ_IDLE;
        asrt_cnt_d = '0;
        hold_cnt_d = '0;
      end
    endcase

    receiver_rst_d = (state_d == RSQ_ASSERT);
    busy_d         = (state_d != RSQ_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= RSQ_IDLE;
      asrt_cnt_q     <= '0;
      hold_cnt_q     <= '0;
      cause_q        <= '0;
      receiver_rst_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      asrt_cnt_q     <= asrt_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      cause_q        <= cause_d;
      receiver_rst_q <= receiver_rst_d;
      busy_q         <= busy_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_event_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (event_inc),
    .clr   (clr_cnt),
    .value (event_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (drop_inc),
    .clr   (clr_cnt),
    .value (drop_cnt)
  );

  assign receiver_rst = receiver_rst_q;
  assign busy         = busy_q;
  assign rst_cause    = cause_q;

endmodule

// File: tb/tb_rx_reset_sequencer.sv
// Directed bench for rx_reset_sequencer; narrow statistics counters make saturation reachable.
module tb_rx_reset_sequencer;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable;
  logic [1:0]    rst_req;
  logic          sw_rst_req;
  logic [7:0]    rst_len;
  logic [15:0]   holdoff_len;
  logic          clr_cnt;
  logic          receiver_rst;
  logic          busy;
  logic [2:0]    rst_cause;
  logic [CW-1:0] event_cnt;
  logic [CW-1:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rx_reset_sequencer #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .rst_req      (rst_req),
    .sw_rst_req   (sw_rst_req),
    .rst_len      (rst_len),
    .holdoff_len  (holdoff_len),
    .clr_cnt      (clr_cnt),
    .receiver_rst (receiver_rst),
    .busy         (busy),
    .rst_cause    (rst_cause),
    .event_cnt    (event_cnt),
    .drop_cnt     (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; rst_req = '0; sw_rst_req = 1'b0;
    rst_len = '0; holdoff_len = '0; clr_cnt = 1'b0;
    tick(); tick();
    chk("reset_rr", receiver_rst, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cause", rst_cause, 0);
    chk("reset_event", event_cnt, 0);
    chk("reset_drop", drop_cnt, 0);
    rstn = 1'b1;
    tick();

    // Basic: L=4, H=10 -> 4 cycles reset, 14 cycles busy
    enable = 1'b1; rst_len = 8'd4; holdoff_len = 16'd10;
    rst_req = 2'b01;
    tick();
    rst_req = 2'b00;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("basic_rr_%0d", i), receiver_rst, (i < 4) ? 1 : 0);
      chk($sformatf("basic_busy_%0d", i), busy, (i < 14) ? 1 : 0);
      tick();
    end
    chk("basic_cause", rst_cause, 3'b001);
    chk("basic_event", event_cnt, 1);
    chk("basic_drop", drop_cnt, 0);

    // Holdoff drops: request held through the whole sequence but released before IDLE sample
    clear_stats();
    chk("clr_event", event_cnt, 0);
    rst_len = 8'd2; holdoff_len = 16'd8;
    rst_req = 2'b10;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold_rr_%0d", i), receiver_rst, (i < 2) ? 1 : 0);
      chk($sformatf("hold_busy_%0d", i), busy, 1);
      tick();
    end
    rst_req = 2'b00;
    chk("hold_idle_busy", busy, 0);
    chk("hold_drop", drop_cnt, 8);
    tick();
    chk("hold_event", event_cnt, 1);
    chk("hold_cause", rst_cause, 3'b010);

    // Back-to-back: request still high at the first IDLE sample restarts
    rst_req = 2'b10;
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("b2b_idle_busy", busy, 0);
    tick();
    chk("b2b_rr", receiver_rst, 1);
    chk("b2b_event", event_cnt, 3);
    chk("b2b_drop", drop_cnt, 16 % 16 == 0 ? 15 : 0);
    rst_req = 2'b00;
    for (int i = 0; i < 10; i++) tick();
    chk("b2b_done", busy, 0);

    // Zero lengths: three 1-cycle resets, pulses every 3 cycles
    clear_stats();
    rst_len = 8'd0; holdoff_len = 16'd0;
    for (int p = 0; p < 3; p++) begin
      rst_req = 2'b01;
      tick();
      rst_req = 2'b00;
      chk($sformatf("zero_rr_on_%0d", p), receiver_rst, 1);
      chk($sformatf("zero_busy_on_%0d", p), busy, 1);
      tick();
      chk($sformatf("zero_rr_off1_%0d", p), receiver_rst, 0);
      chk($sformatf("zero_busy_off1_%0d", p), busy, 0);
      tick();
      chk($sformatf("zero_busy_off2_%0d", p), busy, 0);
    end
    chk("zero_event", event_cnt, 3);
    chk("zero_drop", drop_cnt, 0);

    // Software override during holdoff cycle 3, with a simultaneous hardware drop
    clear_stats();
    rst_len = 8'd2; holdoff_len = 16'd10;
    rst_req = 2'b01;
    tick();
    rst_req = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    chk("sw_pre_rr", receiver_rst, 0);
    chk("sw_pre_busy", busy, 1);
    sw_rst_req = 1'b1; rst_req = 2'b01;
    tick();
    sw_rst_req = 1'b0; rst_req = 2'b00;
    chk("sw_rr", receiver_rst, 1);
    chk("sw_cause", rst_cause, 3'b100);
    chk("sw_event", event_cnt, 2);
    chk("sw_drop", drop_cnt, 1);
    tick();
    chk("sw_rr1", receiver_rst, 1);
    tick();
    chk("sw_rr2", receiver_rst, 0);
    chk("sw_hold_busy", busy, 1);
    for (int i = 0; i < 10; i++) tick();
    chk("sw_done", busy, 0);

    // Enable low: hardware requests in IDLE ignored
    clear_stats();
    enable = 1'b0;
    rst_req = 2'b11;
    tick();
    rst_req = 2'b00;
    chk("dis_rr", receiver_rst, 0);
    chk("dis_busy", busy, 0);
    tick();
    chk("dis_event", event_cnt, 0);
    chk("dis_cause", rst_cause, 3'b100);

    // Cause accumulation during ASSERT without extending the reset
    enable = 1'b1; rst_len = 8'd4; holdoff_len = 16'd0;
    rst_req = 2'b01;
    tick();
    rst_req = 2'b00;
    chk("acc_cause0", rst_cause, 3'b001);
    tick();
    rst_req = 2'b10;
    tick();
    rst_req = 2'b00;
    chk("acc_cause", rst_cause, 3'b011);
    chk("acc_rr2", receiver_rst, 1);
    tick();
    chk("acc_rr3", receiver_rst, 1);
    tick();
    chk("acc_rr4", receiver_rst, 0);
    chk("acc_busy4", busy, 0);
    chk("acc_event", event_cnt, 1);
    chk("acc_drop", drop_cnt, 0);

    // rstn in the middle of ASSERT
    rst_len = 8'd5; holdoff_len = 16'd3;
    rst_req = 2'b01;
    tick();
    rst_req = 2'b00;
    tick();
    chk("mid_rr", receiver_rst, 1);
    rstn = 1'b0;
    tick();
    chk("mid_rst_rr", receiver_rst, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cause", rst_cause, 0);
    chk("mid_rst_event", event_cnt, 0);
    rstn = 1'b1;
    tick();
    chk("mid_rst_stay", busy, 0);

    // Event saturation: 1-cycle sequences every 2 cycles, 20 of them
    rst_len = 8'd0; holdoff_len = 16'd0;
    rst_req = 2'b01;
    for (int i = 0; i < 40; i++) tick();
    rst_req = 2'b00;
    tick(); tick();
    chk("sat_event", event_cnt, 15);
    chk("sat_event_drop", drop_cnt, 0);

    // Drop saturation inside a long holdoff
    rst_len = 8'd1; holdoff_len = 16'd30;
    rst_req = 2'b01;
    for (int i = 0; i < 25; i++) tick();
    rst_req = 2'b00;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_drop_idle", busy, 0);
    chk("sat_drop", drop_cnt, 15);

    // Clear wins over a simultaneous trigger
    clr_cnt = 1'b1; rst_req = 2'b01;
    tick();
    clr_cnt = 1'b0; rst_req = 2'b00;
    chk("clr_win_event", event_cnt, 0);
    chk("clr_win_drop", drop_cnt, 0);
    chk("clr_win_rr", receiver_rst, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
